cam_sccb_init: RTL and testbench
================================

# cam_sccb_init

Camera power-up sequencer and SCCB register loader on the mclk/mreset_n domain, downstream of the clock/reset generator. On a start pulse it sequences the sensor's power-down and reset pins, waits for the sensor to settle, then writes a register table to the camera over SCCB as 3-phase write transactions. It reports completion with busy/done and, optionally, an acknowledge error.

## Interface
- CLK_DIV, 25: mclk cycles per SCCB quarter-bit; SCL period = 4*CLK_DIV. Range 1..255.
- RST_HOLD, 1000: mclk cycles for each of the PWDN and RST phases. Range 1..2^24-1.
- SETTLE, 100000: mclk cycles from reset release to the first SCCB start. Range 1..2^24-1.
- DEV_ADDR, 8'h42: SCCB write ID byte.
- NUM_REGS, 64: table length. Range 1..256.

Ports:
- mclk  in  1  system clock.
- mreset_n  in  1  reset, asynchronous, active-low; clock mclk.
- start  in  1  one-cycle pulse; starts the full sequence.
- tbl_idx  out  8  table index.
- tbl_data  in  16  {reg_addr[15:8], value[7:0]}; valid one cycle after tbl_idx changes.
- cam_pwdn  out  1  sensor power-down, active-high.
- cam_rst_n  out  1  sensor reset, active-low.
- sccb_scl  out  1  SCCB clock.
- sccb_sda_o  out  1  SDA drive value.
- sccb_sda_oe  out  1  SDA output enable; 0 releases the line.
- sccb_sda_i  in  1  SDA pad input.
- busy  out  1  sequence in progress.
- done  out  1  sequence finished; held until the next start.
- err  out  1  NACK abort; always 0 when the feature is compiled out.

## Operation
- Reset values (all outputs registered):
  - tbl_idx=0, cam_pwdn=1, cam_rst_n=0.
  - scl=1, sda_o=1, sda_oe=0.
  - busy=0, done=0, err=0.
- States: IDLE, PWDN, RST, SETTLE, FETCH, START, BYTE, STOP, GAP, DONE.
- IDLE/DONE: on start, go to PWDN; busy=1; done=0, err=0, tbl_idx=0.
- start is ignored in every other state.
- PWDN: pwdn=1, rst_n=0 for RST_HOLD cycles.
- RST: pwdn=0, rst_n=0 for RST_HOLD cycles.
- SETTLE: rst_n=1 for SETTLE cycles.
- FETCH: drive tbl_idx; latch tbl_data on the second cycle.
  - Latched value 16'hFFFF is an end marker: go to DONE.
  - Otherwise go to START.
- START: SDA 1->0 while SCL=1, then SCL->0.
- BYTE: send DEV_ADDR, reg_addr, value; each byte 8 bits MSB first plus a 9th bit with sda_oe=0.
- STOP: SDA 0->1 while SCL=1.
- GAP: 4 quarter-bits idle (scl=1, sda_o=1, sda_oe=0).
  - Then increment tbl_idx; if tbl_idx reaches NUM_REGS go to DONE, else go to FETCH.
- DONE: busy=0, done=1, cam_rst_n=1, cam_pwdn=0.
- Delay counter is 24 bits; quarter counter is 8 bits; tbl_idx counting uses 9 bits internally so NUM_REGS=256 terminates.

## Timing
- busy rises the cycle after start is sampled; cam_pwdn falls RST_HOLD cycles later.
- cam_rst_n rises RST_HOLD cycles after cam_pwdn falls.
- First SDA fall occurs SETTLE+2 cycles after cam_rst_n rises (FETCH takes 2 cycles).
- Bit timing, per data bit, each quarter CLK_DIV cycles:
  - q0: SCL=0, SDA updated.
  - q1: SCL=0.
  - q2 and q3: SCL=1.
- SDA never changes while SCL=1, except at START and STOP.
- START: 2 quarters. STOP: 3 quarters (SDA low with SCL low, SCL high, SDA high).
- Transaction length: 2 + 27*4 + 3 + 4 = 117 quarters, including the gap.
- mreset_n asserted at any point forces all outputs to reset values immediately; the sequence does not resume afterwards.

## Configuration
- SCCB_ACK_CHECK_EN defined:
  - sccb_sda_i is sampled at the last cycle of q2 of every 9th bit.
  - A 1 (NACK) finishes the current bit, then issues STOP.
  - After STOP: err=1, enter DONE with done=1.
- SCCB_ACK_CHECK_EN undefined:
  - The 9th bit is don't-care; sccb_sda_i is unused.
  - err is tied to 0.

## Test plan
- Reset → all outputs at reset values; start held 0 for 100 cycles → no output toggles.
- CLK_DIV=2, RST_HOLD=8, SETTLE=16, start → cam_pwdn falls 8 cycles after busy rises; cam_rst_n rises 8 cycles later; SDA falls 18 cycles after that.
- NUM_REGS=3, table {1280,1101,6B4A} → bus monitor decodes 42/12/80, 42/11/01, 42/6B/4A; tbl_idx steps 0,1,2; done=1, busy=0 after the third STOP plus gap.
- Table {1280,FFFF,...} → exactly one transaction, then done=1.
- Slave drives SDA=1 on the ACK bit of the reg byte: with SCCB_ACK_CHECK_EN → STOP follows, err=1, done=1, no value byte sent; without it → all 3 transactions complete, err=0.
- start pulsed while busy → ignored; mreset_n low mid-byte → scl=1, sda_oe=0, cam_pwdn=1 in the same cycle, and the sequence stays in IDLE after release.

Source files
------------

// File: rtl/cam_sccb_init_if.sv
// Table-fetch and SCCB pad bundle between cam_sccb_init (master) and its
// register table / IO ring (slave).
interface cam_sccb_init_if;
  logic [7:0]  tbl_idx;
  logic [15:0] tbl_data;
  logic        sccb_scl;
  logic        sccb_sda_o;
  logic        sccb_sda_oe;
  logic        sccb_sda_i;

  modport master (
    output tbl_idx,
    input  tbl_data,
    output sccb_scl,
    output sccb_sda_o,
    output sccb_sda_oe,
    input  sccb_sda_i
  );

  modport slave (
    input  tbl_idx,
    output tbl_data,
    input  sccb_scl,
    input  sccb_sda_o,
    input  sccb_sda_oe,
    output sccb_sda_i
  );
endinterface

// File: rtl/cam_sccb_init.sv
// Camera power-up sequencer and SCCB 3-phase register-table loader.
// Optional feature: define SCCB_ACK_CHECK_EN to abort on a NACK and raise err.
module cam_sccb_init #(
  parameter int unsigned CLK_DIV  = 25,
  parameter int unsigned RST_HOLD = 1000,
  parameter int unsigned SETTLE   = 100000,
  parameter logic [7:0]  DEV_ADDR = 8'h42,
  parameter int unsigned NUM_REGS = 64
) (
  input  logic            mclk,
  input  logic            mreset_n,
  input  logic            start,
  cam_sccb_init_if.master bus,
  output logic            cam_pwdn,
  output logic            cam_rst_n,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam logic [23:0] HOLD_LD   = 24'(RST_HOLD - 1);
  localparam logic [23:0] SETTLE_LD = 24'(SETTLE - 1);
  localparam logic [7:0]  QTR_LD    = 8'(CLK_DIV - 1);
  localparam logic [8:0]  LAST_IDX  = 9'(NUM_REGS);

  typedef enum logic [3:0] {
    S_IDLE, S_PWDN, S_RST, S_SETTLE, S_FETCH,
    S_START, S_BYTE, S_STOP, S_GAP, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] dcnt_q, dcnt_d;
  logic [7:0]  qcnt_q, qcnt_d;
  logic [1:0]  qph_q, qph_d;
  logic [3:0]  bitn_q, bitn_d;
  logic [1:0]  bytn_q, bytn_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [15:0] data_q, data_d;
  logic [8:0]  idx_q, idx_d;
  logic        nack_q, nack_d;
  logic        scl_q, scl_d;
  logic        sda_o_q, sda_o_d;
  logic        sda_oe_q, sda_oe_d;
  logic        pwdn_q, pwdn_d;
  logic        rst_n_q, rst_n_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        qend;
  logic        go_done;
  logic [7:0]  next_byte;
  logic [8:0]  idx_inc;

  assign qend = (qcnt_q == '0);

`ifndef SCCB_ACK_CHECK_EN
  logic unused_sda_i;
  assign unused_sda_i = bus.sccb_sda_i;
`endif

  always_ff @(posedge mclk or negedge mreset_n) begin
    if (!mreset_n) begin
      state_q  <= S_IDLE;
      dcnt_q   <= '0;
      qcnt_q   <= '0;
      qph_q    <= '0;
      bitn_q   <= '0;
      bytn_q   <= '0;
      shreg_q  <= '0;
      data_q   <= '0;
      idx_q    <= '0;
      nack_q   <= 1'b0;
      scl_q    <= 1'b1;
      sda_o_q  <= 1'b1;
      sda_oe_q <= 1'b0;
      pwdn_q   <= 1'b1;
      rst_n_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dcnt_q   <= dcnt_d;
      qcnt_q   <= qcnt_d;
      qph_q    <= qph_d;
      bitn_q   <= bitn_d;
      bytn_q   <= bytn_d;
      shreg_q  <= shreg_d;
      data_q   <= data_d;
      idx_q    <= idx_d;
      nack_q   <= nack_d;
      scl_q    <= scl_d;
      sda_o_q  <= sda_o_d;
      sda_oe_q <= sda_oe_d;
      pwdn_q   <= pwdn_d;
      rst_n_q  <= rst_n_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Outputs are registered: each transition computes the pin levels for the
  // quarter/state being entered, so pins change on the same edge as the state.
  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    qcnt_d    = qcnt_q;
    qph_d     = qph_q;
    bitn_d    = bitn_q;
    bytn_d    = bytn_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    idx_d     = idx_q;
    nack_d    = nack_q;
    scl_d     = scl_q;
    sda_o_d   = sda_o_q;
    sda_oe_d  = sda_oe_q;
    pwdn_d    = pwdn_q;
    rst_n_d   = rst_n_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    go_done   = 1'b0;
    next_byte = (bytn_q == 2'd0) ? data_q[15:8] : data_q[7:0];
    idx_inc   = idx_q + 9'd1;

    if (state_q inside {S_START, S_BYTE, S_STOP, S_GAP})
      qcnt_d = qend ? QTR_LD : qcnt_q - 8'd1;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_PWDN;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          nack_d  = 1'b0;
          idx_d   = '0;
          pwdn_d  = 1'b1;
          rst_n_d = 1'b0;
          dcnt_d  = HOLD_LD;
        end
      end
      S_PWDN: begin
        dcnt_d = dcnt_q - 24'd1;
        if (dcnt_q == '0) begin
          state_d = S_RST;
          pwdn_d  = 1'b0;
          dcnt_d  = HOLD_LD;
        end
      end
      S_RST: begin
        dcnt_d = dcnt_q - 24'd1;
        if (dcnt_q == '0) begin
          state_d = S_SETTLE;
          rst_n_d = 1'b1;
          dcnt_d  = SETTLE_LD;
        end
      end
      S_SETTLE: begin
        dcnt_d = dcnt_q - 24'd1;
        if (dcnt_q == '0) begin
          state_d = S_FETCH;
          dcnt_d  = 24'd1;
        end
      end
      S_FETCH: begin
        dcnt_d = dcnt_q - 24'd1;
        if (dcnt_q == '0) begin
          data_d = bus.tbl_data;
          if (bus.tbl_data == 16'hFFFF) begin
            go_done = 1'b1;
          end else begin
            state_d  = S_START;
            qcnt_d   = QTR_LD;
            qph_d    = '0;
            scl_d    = 1'b1;
            sda_o_d  = 1'b0;
            sda_oe_d = 1'b1;
          end
        end
      end
      S_START: begin
        if (qend) begin
          if (qph_q == 2'd0) begin
            qph_d = 2'd1;
            scl_d = 1'b0;
          end else begin
            state_d = S_BYTE;
            qph_d   = '0;
            bitn_d  = '0;
            bytn_d  = '0;
            shreg_d = DEV_ADDR;
            sda_o_d = DEV_ADDR[7];
          end
        end
      end
      S_BYTE: begin
        if (qend) begin
          qph_d = qph_q + 2'd1;
          case (qph_q)
            2'd1: scl_d = 1'b1;
            2'd2: begin
`ifdef SCCB_ACK_CHECK_EN
              if (bitn_q == 4'd8 && bus.sccb_sda_i)
                nack_d = 1'b1;
`endif
            end
            2'd3: begin
              scl_d = 1'b0;
              if (bitn_q == 4'd8) begin
                if (bytn_q == 2'd2 || nack_q) begin
                  state_d  = S_STOP;
                  qph_d    = '0;
                  sda_o_d  = 1'b0;
                  sda_oe_d = 1'b1;
                end else begin
                  bytn_d   = bytn_q + 2'd1;
                  bitn_d   = '0;
                  shreg_d  = next_byte;
                  sda_o_d  = next_byte[7];
                  sda_oe_d = 1'b1;
                end
              end else if (bitn_q == 4'd7) begin
                bitn_d   = 4'd8;
                sda_o_d  = 1'b1;
                sda_oe_d = 1'b0;
              end else begin
                bitn_d  = bitn_q + 4'd1;
                shreg_d = shreg_q << 1;
                sda_o_d = shreg_q[6];
              end
            end
            default: ;
          endcase
        end
      end
      S_STOP: begin
        if (qend) begin
          qph_d = qph_q + 2'd1;
          if (qph_q == 2'd0) begin
            scl_d = 1'b1;
          end else if (qph_q == 2'd1) begin
            sda_o_d = 1'b1;
          end else if (nack_q) begin
`ifdef SCCB_ACK_CHECK_EN
            err_d = 1'b1;
`endif
            go_done = 1'b1;
          end else begin
            state_d  = S_GAP;
            qph_d    = '0;
            sda_oe_d = 1'b0;
          end
        end
      end
      S_GAP: begin
        if (qend) begin
          qph_d = qph_q + 2'd1;
          if (qph_q == 2'd3) begin
            idx_d = idx_inc;
            if (idx_inc == LAST_IDX) begin
              go_done = 1'b1;
            end else begin
              state_d = S_FETCH;
              dcnt_d  = 24'd1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (go_done) begin
      state_d  = S_DONE;
      busy_d   = 1'b0;
      done_d   = 1'b1;
      pwdn_d   = 1'b0;
      rst_n_d  = 1'b1;
      scl_d    = 1'b1;
      sda_o_d  = 1'b1;
      sda_oe_d = 1'b0;
    end
  end

  assign bus.tbl_idx     = idx_q[7:0];
  assign bus.sccb_scl    = scl_q;
  assign bus.sccb_sda_o  = sda_o_q;
  assign bus.sccb_sda_oe = sda_oe_q;
  assign cam_pwdn        = pwdn_q;
  assign cam_rst_n       = rst_n_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign err             = err_q;

endmodule

// File: tb/tb_cam_sccb_init.sv
// Self-checking bench for cam_sccb_init: SCCB bus monitor plus a table-level
// reference model of the expected transactions, pin timing and final status.
`timescale 1ns/1ps
module tb_cam_sccb_init;
  localparam int unsigned CLK_DIV  = 2;
  localparam int unsigned RST_HOLD = 8;
  localparam int unsigned SETTLE   = 16;
  localparam int unsigned NUM_REGS = 3;
  localparam logic [7:0]  DEV      = 8'h42;
`ifdef SCCB_ACK_CHECK_EN
  localparam bit ACK_CHECK = 1'b1;
`else
  localparam bit ACK_CHECK = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] n;
    logic [23:0] bytes;
    logic [7:0]  idx;
  } trans_t;

  logic mclk = 1'b0;
  logic mreset_n;
  logic start = 1'b0;
  logic cam_pwdn, cam_rst_n, busy, done, err;
  logic sda_pad;
  logic slave_pull = 1'b0;

  cam_sccb_init_if bus();

  cam_sccb_init #(
    .CLK_DIV (CLK_DIV),
    .RST_HOLD(RST_HOLD),
    .SETTLE  (SETTLE),
    .DEV_ADDR(DEV),
    .NUM_REGS(NUM_REGS)
  ) dut (
    .mclk     (mclk),
    .mreset_n (mreset_n),
    .start    (start),
    .bus      (bus),
    .cam_pwdn (cam_pwdn),
    .cam_rst_n(cam_rst_n),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 mclk = ~mclk;

  logic [15:0] tbl [NUM_REGS];
  always @(posedge mclk)
    bus.tbl_data <= (bus.tbl_idx < NUM_REGS) ? tbl[bus.tbl_idx] : 16'hFFFF;

  assign sda_pad        = bus.sccb_sda_oe ? bus.sccb_sda_o : !slave_pull;
  assign bus.sccb_sda_i = sda_pad;

  // ---------------- bus monitor ----------------
  trans_t got[$];
  trans_t exp_q[$];
  int     cyc = 0;
  int     nack_tr = -1, nack_byte = 0;
  int     tr_count = 0;
  bit     in_tr = 0, first_seen = 0;
  int     bitcnt = 0, bytecnt = 0, nrise = 0, last_rise = 0, high_viol = 0;
  logic [7:0]  shift;
  logic [23:0] cur_bytes;
  logic [7:0]  cur_idx;
  logic prev_scl = 1'b1, prev_sda = 1'b1, prev_busy = 1'b0, prev_pwdn = 1'b1, prev_rst = 1'b0;
  int   t_busy, t_pwdn, t_rst, t_sda;

  always @(negedge mclk) begin
    cyc++;
    if (!mreset_n) begin
      in_tr = 0; slave_pull = 1'b0; prev_scl = 1'b1; prev_sda = 1'b1;
    end else begin
      if (prev_scl && bus.sccb_scl && prev_sda && !sda_pad) begin
        in_tr = 1; bitcnt = 0; bytecnt = 0; nrise = 0; cur_bytes = '0;
        cur_idx = bus.tbl_idx;
        if (!first_seen) begin first_seen = 1; t_sda = cyc; end
      end else if (in_tr && prev_scl && bus.sccb_scl && !prev_sda && sda_pad) begin
        got.push_back('{n: 32'(bytecnt), bytes: cur_bytes, idx: cur_idx});
        in_tr = 0; tr_count++;
      end else if (in_tr && !prev_scl && bus.sccb_scl) begin
        last_rise = cyc; nrise++;
        if (bitcnt < 8) shift = {shift[6:0], sda_pad};
        bitcnt++;
        if (bitcnt == 9) begin
          cur_bytes = {cur_bytes[15:0], shift};
          bytecnt++; bitcnt = 0;
        end
      end else if (in_tr && prev_scl && !bus.sccb_scl) begin
        if (nrise > 0 && cyc - last_rise != 2 * CLK_DIV) high_viol++;
        slave_pull = (bitcnt == 8) && !(nack_tr == tr_count && nack_byte == bytecnt);
      end
      prev_scl = bus.sccb_scl;
      prev_sda = sda_pad;
    end
    if (busy && !prev_busy) t_busy = cyc;
    if (!cam_pwdn && prev_pwdn) t_pwdn = cyc;
    if (cam_rst_n && !prev_rst) t_rst = cyc;
    prev_busy = busy; prev_pwdn = cam_pwdn; prev_rst = cam_rst_n;
  end

  // ---------------- checking ----------------
  int unsigned nvec = 0, nerr = 0;
  logic exp_err;
  logic [7:0] exp_idx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Expected bus traffic derived from the table contents and the slave's NACK plan.
  task automatic model();
    trans_t t;
    exp_q.delete();
    exp_err = 1'b0;
    exp_idx = 8'(NUM_REGS);
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (tbl[i] == 16'hFFFF) begin exp_idx = 8'(i); break; end
      t.idx = 8'(i); t.n = 3; t.bytes = {DEV, tbl[i]};
      if (ACK_CHECK && nack_tr == i) begin
        t.n = 32'(nack_byte + 1);
        t.bytes = {DEV, tbl[i]} >> (8 * (2 - nack_byte));
        exp_q.push_back(t);
        exp_err = 1'b1; exp_idx = 8'(i);
        break;
      end
      exp_q.push_back(t);
    end
  endtask

  task automatic run(input string name, input bit pulse_busy);
    int n;
    model();
    got.delete(); tr_count = 0; first_seen = 0;
    t_busy = -1; t_pwdn = -1; t_rst = -1; t_sda = -1;
    @(negedge mclk) start = 1'b1;
    @(negedge mclk) start = 1'b0;
    if (pulse_busy) begin
      repeat (11) @(negedge mclk);
      start = 1'b1;
      @(negedge mclk) start = 1'b0;
    end
    n = 0;
    while (!done && n < 5000) begin @(negedge mclk); n++; end
    check({name, "_done"}, done, 1'b1);
    check({name, "_busy"}, busy, 1'b0);
    check({name, "_err"}, err, exp_err);
    check({name, "_idx"}, bus.tbl_idx, exp_idx);
    check({name, "_pins"}, {cam_pwdn, cam_rst_n, bus.sccb_scl, bus.sccb_sda_oe}, 4'b0110);
    check({name, "_t_pwdn"}, t_pwdn - t_busy, RST_HOLD);
    check({name, "_t_rst"}, t_rst - t_pwdn, RST_HOLD);
    if (exp_q.size() > 0) check({name, "_t_sda"}, t_sda - t_rst, SETTLE + 2);
    check({name, "_ntr"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got.size()) check($sformatf("%s_tr%0d", name, i), got[i], exp_q[i]);
  endtask

  function automatic logic [15:0] rnd_entry();
    logic [15:0] v = 16'($urandom);
    return (v == 16'hFFFF) ? 16'h1234 : v;
  endfunction

  initial begin
    logic [9:0] snap;
    int toggles, n, end_pos, saved;
    mreset_n = 1'b0;
    for (int i = 0; i < int'(NUM_REGS); i++) tbl[i] = 16'h0000;
    repeat (3) @(negedge mclk);
    check("rst_idx", bus.tbl_idx, 8'h00);
    check("rst_pwdn", cam_pwdn, 1'b1);
    check("rst_rst_n", cam_rst_n, 1'b0);
    check("rst_scl", bus.sccb_scl, 1'b1);
    check("rst_sda_o", bus.sccb_sda_o, 1'b1);
    check("rst_sda_oe", bus.sccb_sda_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);

    mreset_n = 1'b1;
    @(negedge mclk);
    snap = {bus.tbl_idx[1:0], cam_pwdn, cam_rst_n, bus.sccb_scl, bus.sccb_sda_o, bus.sccb_sda_oe, busy, done, err};
    toggles = 0;
    repeat (100) begin
      @(negedge mclk);
      if ({bus.tbl_idx[1:0], cam_pwdn, cam_rst_n, bus.sccb_scl, bus.sccb_sda_o, bus.sccb_sda_oe, busy, done, err} != snap)
        toggles++;
    end
    check("idle_toggles", toggles, 0);

    tbl[0] = 16'h1280; tbl[1] = 16'h1101; tbl[2] = 16'h6B4A;
    nack_tr = -1;
    run("basic", 1'b1);

    tbl[0] = rnd_entry(); tbl[1] = 16'hFFFF; tbl[2] = rnd_entry();
    run("endmark", 1'b0);

    tbl[0] = 16'h1280; tbl[1] = 16'h1101; tbl[2] = 16'h6B4A;
    nack_tr = 0; nack_byte = 1;
    run("nack_reg", 1'b0);

    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < int'(NUM_REGS); i++) tbl[i] = rnd_entry();
      end_pos = $urandom_range(0, 3);
      if (end_pos < 3) tbl[end_pos] = 16'hFFFF;
      if ($urandom_range(0, 1) == 1) begin
        nack_tr = $urandom_range(0, 2); nack_byte = $urandom_range(0, 2);
      end else nack_tr = -1;
      run($sformatf("rand%0d", r), 1'b0);
    end
    check("scl_high_time", high_viol, 0);

    // asynchronous reset in the middle of a byte
    tbl[0] = 16'h1280; tbl[1] = 16'h1101; tbl[2] = 16'h6B4A;
    nack_tr = -1; got.delete();
    @(negedge mclk) start = 1'b1;
    @(negedge mclk) start = 1'b0;
    n = 0;
    while (!(in_tr && bitcnt == 3) && n < 2000) begin @(negedge mclk); n++; end
    check("midbyte_reached", in_tr && bitcnt == 3, 1'b1);
    #2 mreset_n = 1'b0;
    #1;
    check("arst_scl", bus.sccb_scl, 1'b1);
    check("arst_sda_oe", bus.sccb_sda_oe, 1'b0);
    check("arst_pwdn", cam_pwdn, 1'b1);
    check("arst_busy", busy, 1'b0);
    repeat (3) @(negedge mclk);
    mreset_n = 1'b1;
    saved = got.size();
    repeat (300) @(negedge mclk);
    check("post_busy", busy, 1'b0);
    check("post_done", done, 1'b0);
    check("post_pins", {cam_pwdn, cam_rst_n, bus.sccb_scl, bus.sccb_sda_oe}, 4'b1010);
    check("post_no_traffic", got.size(), saved);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
